// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: clocked valid/ready command front-end for the combinational 4-bit ALU.
// Optional feature macro ALU_DIVZ_CHECK_EN: reject DIV by zero without issuing it to the ALU.
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_opcode,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_err,
    output logic [7:0] op_count,
    input  logic       cnt_clr
);

    // state   | meaning
    // ST_IDLE | ready to accept a command
    // ST_WAIT | operands held on ALU pins, settle timer running
    // ST_RESP | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_DIV    = 3'b011;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       settle_tc;
    logic       divz;
    logic       issue_en;
    logic       capture_en;
    logic       reject_en;
    logic       rsp_hs;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign settle_tc = (settle_cnt == 4'd1);

`ifdef ALU_DIVZ_CHECK_EN
    assign divz = (cmd_opcode == OP_DIV) && (cmd_b == 4'h0);
`else
    assign divz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue_en   = 1'b0;
        capture_en = 1'b0;
        reject_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (divz) begin
                        reject_en = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        issue_en  = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (settle_tc) begin
                    capture_en = 1'b1;
                    state_nxt  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Settle timer: loaded on issue, terminal count 1 marks the sampling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (issue_en) begin
            settle_cnt <= SETTLE_LD;
        end else if (state == ST_WAIT) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 4'h0;
            alu_b      <= 4'h0;
            alu_opcode <= 3'b000;
        end else if (issue_en) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_opcode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= 8'h00;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (capture_en) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_err    <= 1'b0;
        end else if (reject_en) begin
            rsp_result <= 8'hFF;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b1;
        end
    end

    // A clear coinciding with a handshake still counts that response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 8'h00;
        end else if (cnt_clr) begin
            op_count <= rsp_hs ? 8'h01 : 8'h00;
        end else if (rsp_hs && (op_count != 8'hFF)) begin
            op_count <= op_count + 8'h01;
        end
    end

endmodule
